// File: rtl/mem_serial_responder_pkg.sv
// Shared types and sizing for the serial memory responder.
// Message codes, FSM state encodings and the write-request payload.
package mem_serial_responder_pkg;

  localparam int unsigned IO_BITS       = 2;
  localparam int unsigned MSG_TYPE_BITS = IO_BITS;
  localparam int unsigned MEM_ADDR_BITS = 10;
  localparam int unsigned RESP_DELAY    = 1;
  localparam int unsigned WORD_BITS     = 16;
  localparam int unsigned ADDR_BEATS    = WORD_BITS / IO_BITS;
  localparam int unsigned BYTE_BEATS    = 8 / IO_BITS;
  localparam int unsigned BEAT_CNT_BITS = $clog2(ADDR_BEATS);
  localparam int unsigned MEM_BYTES     = 1 << MEM_ADDR_BITS;
  localparam int unsigned DLY_BITS      = (RESP_DELAY > 1) ? $clog2(RESP_DELAY) : 1;
  localparam int unsigned DLY_LAST      = (RESP_DELAY > 0) ? RESP_DELAY - 1 : 0;

  typedef enum logic [MSG_TYPE_BITS-1:0] {
    MSG_NONE   = 2'd0,
    MSG_READ   = 2'd1,
    MSG_WRITE  = 2'd2,
    MSG_WRITE8 = 2'd3
  } msg_t;

  typedef enum logic [1:0] {RX_IDLE, RX_ADDR, RX_DATA} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_WAIT, TX_START, TX_DATA} tx_state_t;

  typedef struct packed {
    logic                     pend;
    logic                     wide;
  } wr_ctl_t;

  function automatic logic [MEM_ADDR_BITS-1:0] next_addr(input logic [MEM_ADDR_BITS-1:0] a);
    return a + MEM_ADDR_BITS'(1);
  endfunction

endpackage

// File: rtl/mem_serial_responder_if.sv
// Narrow serial pin bundle between the CPU (master) and the memory responder (slave).
interface mem_serial_responder_if;
  import mem_serial_responder_pkg::*;

  logic [IO_BITS-1:0] tx_pins;
  logic [IO_BITS-1:0] rx_pins;
  logic               busy;
  logic               overrun;

  modport master (output tx_pins, input rx_pins, busy, overrun);
  modport slave  (input tx_pins, output rx_pins, busy, overrun);
endinterface

// File: rtl/mem_serial_responder_shifter.sv
// Load/shift register moving STEP bits per cycle, LSB-first; new beats enter at the top.
module mem_serial_responder_shifter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned STEP  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift,
  input  logic [STEP-1:0]  beat_in,
  output logic [WIDTH-1:0] data_q
);

  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = load_val;
    end else if (shift) begin
      data_d = {beat_in, data_q[WIDTH-1:STEP]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

endmodule

// File: rtl/mem_serial_responder.sv
// Far end of the narrow serial memory link: decodes READ/WRITE/WRITE8 requests,
// services them from a local byte RAM and streams read data back on rx_pins.
module mem_serial_responder
  import mem_serial_responder_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  mem_serial_responder_if.slave    bus,
  input  logic [MEM_ADDR_BITS-1:0] peek_addr,
  output logic [7:0]               peek_data
);

  localparam logic [IO_BITS-1:0] START_BEAT = IO_BITS'(1);

  rx_state_t rx_state_q, rx_state_d;
  tx_state_t tx_state_q, tx_state_d;
  msg_t      msg_q, msg_d;
  logic [BEAT_CNT_BITS-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d, data_last;
  logic [DLY_BITS-1:0]      dly_q, dly_d;
  logic [IO_BITS-1:0]       rx_pins_q, rx_pins_d;
  logic rd_pend_q, rd_pend_d, overrun_q, overrun_d, busy_q, busy_d;
  wr_ctl_t wr_q, wr_d;
  logic addr_shift, data_shift, rd_done, resp_load, resp_shift;
  logic [WORD_BITS-1:0] addr_word, data_word, resp_word, resp_load_val;
  logic [MEM_ADDR_BITS-1:0] mem_a;
  logic [7:0] ram_q [MEM_BYTES];
  logic unused_hi;

  // Address and data words hold their value until the next message's payload starts.
  mem_serial_responder_shifter #(.WIDTH(WORD_BITS), .STEP(IO_BITS)) u_addr_sh (
    .clk(clk), .rst(reset), .load(1'b0), .load_val('0), .shift(addr_shift),
    .beat_in(bus.tx_pins), .data_q(addr_word));

  mem_serial_responder_shifter #(.WIDTH(WORD_BITS), .STEP(IO_BITS)) u_data_sh (
    .clk(clk), .rst(reset), .load(1'b0), .load_val('0), .shift(data_shift),
    .beat_in(bus.tx_pins), .data_q(data_word));

  mem_serial_responder_shifter #(.WIDTH(WORD_BITS), .STEP(IO_BITS)) u_resp_sh (
    .clk(clk), .rst(reset), .load(resp_load), .load_val(resp_load_val), .shift(resp_shift),
    .beat_in('0), .data_q(resp_word));

  assign mem_a         = addr_word[MEM_ADDR_BITS-1:0];
  assign resp_load_val = {ram_q[next_addr(mem_a)], ram_q[mem_a]};
  assign data_last     = (msg_q == MSG_WRITE) ? BEAT_CNT_BITS'(ADDR_BEATS - 1)
                                              : BEAT_CNT_BITS'(BYTE_BEATS - 1);
  assign unused_hi     = ^{addr_word[WORD_BITS-1:MEM_ADDR_BITS], resp_word[WORD_BITS-1:IO_BITS]};

  // Request receiver
  always_comb begin
    rx_state_d = rx_state_q;
    msg_d      = msg_q;
    rx_cnt_d   = rx_cnt_q;
    wr_d       = '{pend: 1'b0, wide: wr_q.wide};
    addr_shift = 1'b0;
    data_shift = 1'b0;
    rd_done    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (bus.tx_pins != '0) begin
          msg_d      = msg_t'(bus.tx_pins);
          rx_cnt_d   = '0;
          rx_state_d = RX_ADDR;
        end
      end
      RX_ADDR: begin
        addr_shift = 1'b1;
        rx_cnt_d   = rx_cnt_q + BEAT_CNT_BITS'(1);
        if (rx_cnt_q == BEAT_CNT_BITS'(ADDR_BEATS - 1)) begin
          rx_cnt_d = '0;
          if (msg_q == MSG_READ) begin
            rd_done    = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
          end
        end
      end
      RX_DATA: begin
        data_shift = 1'b1;
        rx_cnt_d   = rx_cnt_q + BEAT_CNT_BITS'(1);
        if (rx_cnt_q == data_last) begin
          wr_d       = '{pend: 1'b1, wide: (msg_q == MSG_WRITE)};
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Response transmitter; a READ arriving while one is still outstanding is dropped
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    dly_d      = dly_q;
    rd_pend_d  = rd_pend_q;
    overrun_d  = overrun_q;
    rx_pins_d  = '0;
    resp_load  = 1'b0;
    resp_shift = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (rd_pend_q) begin
          resp_load  = 1'b1;
          rd_pend_d  = 1'b0;
          dly_d      = '0;
          tx_state_d = (RESP_DELAY == 0) ? TX_START : TX_WAIT;
        end
      end
      TX_WAIT: begin
        dly_d = dly_q + DLY_BITS'(1);
        if (dly_q == DLY_BITS'(DLY_LAST)) tx_state_d = TX_START;
      end
      TX_START: begin
        tx_cnt_d   = '0;
        tx_state_d = TX_DATA;
      end
      TX_DATA: begin
        if (tx_cnt_q == BEAT_CNT_BITS'(ADDR_BEATS - 1)) tx_state_d = TX_IDLE;
        else tx_cnt_d = tx_cnt_q + BEAT_CNT_BITS'(1);
      end
      default: tx_state_d = TX_IDLE;
    endcase
    if (rd_done) begin
      if ((tx_state_q != TX_IDLE) || rd_pend_q) overrun_d = 1'b1;
      else                                      rd_pend_d = 1'b1;
    end
    if (tx_state_d == TX_START) begin
      rx_pins_d = START_BEAT;
    end else if (tx_state_d == TX_DATA) begin
      rx_pins_d  = resp_word[IO_BITS-1:0];
      resp_shift = 1'b1;
    end
    busy_d = (rx_state_d != RX_IDLE) || (tx_state_d != TX_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q <= RX_IDLE;
      tx_state_q <= TX_IDLE;
      msg_q      <= MSG_NONE;
      rx_cnt_q   <= '0;
      tx_cnt_q   <= '0;
      dly_q      <= '0;
      wr_q       <= '0;
      rd_pend_q  <= 1'b0;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
      rx_pins_q  <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      tx_state_q <= tx_state_d;
      msg_q      <= msg_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      dly_q      <= dly_d;
      wr_q       <= wr_d;
      rd_pend_q  <= rd_pend_d;
      overrun_q  <= overrun_d;
      busy_q     <= busy_d;
      rx_pins_q  <= rx_pins_d;
    end
  end

  // Byte RAM: a wide write lands as two byte writes to distinct addresses
  always_ff @(posedge clk) begin
    if (wr_q.pend) begin
      ram_q[mem_a] <= wr_q.wide ? data_word[7:0] : data_word[15:8];
      if (wr_q.wide) ram_q[next_addr(mem_a)] <= data_word[15:8];
    end
  end

  assign peek_data   = ram_q[peek_addr];
  assign bus.rx_pins = rx_pins_q;
  assign bus.busy    = busy_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_mem_serial_responder.sv
// Randomized bench for mem_serial_responder against a byte-array memory model.
module tb_mem_serial_responder;
  import mem_serial_responder_pkg::*;

  localparam int LAT = 2 + int'(RESP_DELAY);

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] peek_addr;
  logic [7:0] peek_data;

  mem_serial_responder_if bus_if ();

  mem_serial_responder dut (
    .clk(clk), .reset(reset), .bus(bus_if), .peek_addr(peek_addr), .peek_data(peek_data));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int prot_err = 0;
  logic [7:0]  mem_m [1024];
  logic [15:0] resp_q [$];
  int          start_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Decode the rx stream into whole responses, tagged with the start-beat cycle
  bit          mon_active = 1'b0;
  int          mon_n, mon_start;
  logic [15:0] mon_val;
  always @(negedge clk) begin
    if (reset) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (bus_if.rx_pins == 2'b01) begin
        mon_active = 1'b1; mon_start = cyc; mon_n = 0; mon_val = '0;
      end else if (bus_if.rx_pins != 2'b00) begin
        prot_err++;
      end
    end else begin
      mon_val[2*mon_n +: 2] = bus_if.rx_pins;
      mon_n++;
      if (mon_n == 8) begin
        resp_q.push_back(mon_val);
        start_q.push_back(mon_start);
        mon_active = 1'b0;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1);
  end

  function automatic void model_write(input msg_t typ, input logic [15:0] addr, input logic [15:0] data);
    logic [9:0] a;
    logic [9:0] a1;
    a  = addr[9:0];
    a1 = a + 10'd1;
    mem_m[a] = data[7:0];
    if (typ == MSG_WRITE) mem_m[a1] = data[15:8];
  endfunction

  function automatic logic [15:0] model_read(input logic [15:0] addr);
    logic [9:0] a;
    logic [9:0] a1;
    a  = addr[9:0];
    a1 = a + 10'd1;
    return {mem_m[a1], mem_m[a]};
  endfunction

  task automatic send(input msg_t typ, input logic [15:0] addr, input logic [15:0] data,
                      output int last_cyc);
    int nb;
    @(negedge clk); bus_if.tx_pins = typ;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); bus_if.tx_pins = addr[2*i +: 2];
    end
    last_cyc = cyc;
    nb = (typ == MSG_WRITE) ? 8 : ((typ == MSG_WRITE8) ? 4 : 0);
    for (int i = 0; i < nb; i++) begin
      @(negedge clk); bus_if.tx_pins = data[2*i +: 2];
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk); bus_if.tx_pins = 2'b00;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic wait_resp(output logic [15:0] val, output int st, output bit ok);
    ok = 1'b0; val = '0; st = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      if (resp_q.size() != 0) begin
        val = resp_q.pop_front(); st = start_q.pop_front(); ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; bus_if.tx_pins = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus_if.tx_pins = 2'b00; reset = 1'b1; peek_addr = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus_if.rx_pins !== 2'b00) begin failures++; $display("FAIL reset_rx got=%b exp=00", bus_if.rx_pins); end
    checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus_if.busy); end
    checks++; if (bus_if.overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", bus_if.overrun); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_prefill();
    int lc;
    logic [15:0] d;
    logic [15:0] a;
    for (int i = 0; i < 512; i++) begin
      d = 16'($urandom);
      a = 16'(2 * i) | (16'($urandom) & 16'hFC00);
      send(MSG_WRITE, a, d, lc);
      model_write(MSG_WRITE, a, d);
    end
    idle(3);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); peek_addr = 10'($urandom); #1;
      checks++;
      if (peek_data !== mem_m[peek_addr]) begin
        failures++; $display("FAIL prefill_peek addr=%h got=%h exp=%h", peek_addr, peek_data, mem_m[peek_addr]);
      end
    end
  endtask

  task automatic test_write8();
    int lc;
    send(MSG_WRITE8, 16'h0012, 16'h00A5, lc);
    model_write(MSG_WRITE8, 16'h0012, 16'h00A5);
    idle(3);
    peek_addr = 10'h012; #1;
    checks++; if (peek_data !== 8'hA5) begin failures++; $display("FAIL write8_peek got=%h exp=a5", peek_data); end
    checks++; if (resp_q.size() != 0) begin failures++; $display("FAIL write8_no_resp got=%0d exp=0", resp_q.size()); end
  endtask

  task automatic test_read_latency();
    int lc, st;
    bit ok;
    logic [15:0] v;
    send(MSG_WRITE, 16'h0040, 16'hBEEF, lc);
    model_write(MSG_WRITE, 16'h0040, 16'hBEEF);
    idle(2);
    send(MSG_READ, 16'h0040, 16'h0000, lc);
    idle(1);
    @(negedge clk);
    checks++; if (bus_if.busy !== 1'b1) begin failures++; $display("FAIL read_busy got=%b exp=1", bus_if.busy); end
    wait_resp(v, st, ok);
    checks++; if (!ok) begin failures++; $display("FAIL read_timeout got=none exp=response"); end
    checks++; if (v !== 16'hBEEF) begin failures++; $display("FAIL read_value got=%h exp=beef", v); end
    checks++; if (st - lc != LAT) begin failures++; $display("FAIL read_latency got=%0d exp=%0d", st - lc, LAT); end
    idle(2);
  endtask

  task automatic test_wrap();
    int lc;
    send(MSG_WRITE, 16'h03FF, 16'h1234, lc);
    model_write(MSG_WRITE, 16'h03FF, 16'h1234);
    idle(3);
    peek_addr = 10'h3FF; #1;
    checks++; if (peek_data !== 8'h34) begin failures++; $display("FAIL wrap_lo got=%h exp=34", peek_data); end
    peek_addr = 10'h000; #1;
    checks++; if (peek_data !== 8'h12) begin failures++; $display("FAIL wrap_hi got=%h exp=12", peek_data); end
  endtask

  task automatic test_overrun();
    int lc, st;
    bit ok;
    logic [15:0] v;
    logic [15:0] exp;
    exp = model_read(16'h0040);
    send(MSG_READ, 16'h0040, 16'h0000, lc);
    send(MSG_READ, 16'h0012, 16'h0000, lc);
    idle(1);
    wait_resp(v, st, ok);
    checks++; if (!ok || v !== exp) begin failures++; $display("FAIL overrun_first got=%h ok=%0d exp=%h", v, ok, exp); end
    repeat (30) @(negedge clk);
    checks++; if (resp_q.size() != 0) begin failures++; $display("FAIL overrun_dropped got=%0d exp=0", resp_q.size()); end
    checks++; if (bus_if.overrun !== 1'b1) begin failures++; $display("FAIL overrun_set got=%b exp=1", bus_if.overrun); end
    do_reset();
    @(negedge clk);
    checks++; if (bus_if.overrun !== 1'b0) begin failures++; $display("FAIL overrun_clear got=%b exp=0", bus_if.overrun); end
  endtask

  task automatic test_write_during_resp();
    int lc, st;
    bit ok;
    logic [15:0] v;
    logic [15:0] exp;
    exp = model_read(16'h0012);
    send(MSG_READ, 16'h0012, 16'h0000, lc);
    send(MSG_WRITE8, 16'h0012, 16'h005A, lc);
    model_write(MSG_WRITE8, 16'h0012, 16'h005A);
    idle(1);
    wait_resp(v, st, ok);
    checks++; if (!ok || v !== exp) begin failures++; $display("FAIL overlap_old_data got=%h ok=%0d exp=%h", v, ok, exp); end
    idle(3);
    peek_addr = 10'h012; #1;
    checks++; if (peek_data !== 8'h5A) begin failures++; $display("FAIL overlap_new_byte got=%h exp=5a", peek_data); end
  endtask

  task automatic test_reset_mid_write();
    int lc, st;
    bit ok;
    logic [15:0] v;
    logic [15:0] exp;
    logic [15:0] partial;
    partial = 16'hCAFE;
    send(MSG_WRITE, 16'h0100, 16'h1357, lc);
    model_write(MSG_WRITE, 16'h0100, 16'h1357);
    idle(2);
    @(negedge clk); bus_if.tx_pins = MSG_WRITE;
    for (int i = 0; i < 8; i++) begin @(negedge clk); bus_if.tx_pins = 2'(16'h0100 >> (2 * i)); end
    for (int i = 0; i < 2; i++) begin @(negedge clk); bus_if.tx_pins = partial[2*i +: 2]; end
    #2; reset = 1'b1; bus_if.tx_pins = 2'b00;
    @(negedge clk);
    checks++; if (bus_if.rx_pins !== 2'b00) begin failures++; $display("FAIL midreset_rx got=%b exp=00", bus_if.rx_pins); end
    checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", bus_if.busy); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    peek_addr = 10'h100; #1;
    checks++; if (peek_data !== mem_m[10'h100]) begin failures++; $display("FAIL midreset_ram0 got=%h exp=%h", peek_data, mem_m[10'h100]); end
    peek_addr = 10'h101; #1;
    checks++; if (peek_data !== mem_m[10'h101]) begin failures++; $display("FAIL midreset_ram1 got=%h exp=%h", peek_data, mem_m[10'h101]); end
    exp = model_read(16'h0100);
    send(MSG_READ, 16'h0100, 16'h0000, lc);
    idle(1);
    wait_resp(v, st, ok);
    checks++; if (!ok || v !== exp) begin failures++; $display("FAIL midreset_read got=%h ok=%0d exp=%h", v, ok, exp); end
    checks++; if (st - lc != LAT) begin failures++; $display("FAIL midreset_latency got=%0d exp=%0d", st - lc, LAT); end
    idle(2);
  endtask

  task automatic test_random();
    int lc, lc2, st, op;
    bit ok;
    logic [15:0] a, a2, d, v, exp;
    msg_t wt;
    for (int n = 0; n < 60; n++) begin
      op = int'($urandom_range(0, 2));
      a  = 16'($urandom);
      d  = 16'($urandom);
      if (op == 0) begin
        wt = ($urandom_range(0, 1) == 1) ? MSG_WRITE : MSG_WRITE8;
        send(wt, a, d, lc);
        model_write(wt, a, d);
        if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
      end else begin
        exp = model_read(a);
        send(MSG_READ, a, 16'h0000, lc);
        if (op == 2) begin
          wt = ($urandom_range(0, 1) == 1) ? MSG_WRITE : MSG_WRITE8;
          d  = 16'($urandom);
          a2 = 16'(a + 16'($urandom_range(0, 2)));
          send(wt, a2, d, lc2);
          model_write(wt, a2, d);
        end
        idle(1);
        wait_resp(v, st, ok);
        checks++;
        if (!ok || v !== exp) begin failures++; $display("FAIL rand_read addr=%h got=%h ok=%0d exp=%h", a, v, ok, exp); end
        checks++;
        if (st - lc != LAT) begin failures++; $display("FAIL rand_latency addr=%h got=%0d exp=%0d", a, st - lc, LAT); end
      end
    end
    idle(20);
    checks++; if (resp_q.size() != 0) begin failures++; $display("FAIL rand_extra_resp got=%0d exp=0", resp_q.size()); end
    checks++; if (bus_if.overrun !== 1'b0) begin failures++; $display("FAIL rand_overrun got=%b exp=0", bus_if.overrun); end
  endtask

  task automatic test_final();
    checks++; if (prot_err != 0) begin failures++; $display("FAIL rx_idle_glitches got=%0d exp=0", prot_err); end
  endtask

  initial begin
    test_reset();
    test_prefill();
    test_write8();
    test_read_latency();
    test_wrap();
    test_overrun();
    test_write_during_resp();
    test_reset_mid_write();
    test_random();
    test_final();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
